// File: rtl/processor_status_register.sv
// 6502-style processor status register: C,Z,I,D,V,N with prioritised load sources, SO pin edge detect.
// Optional `DECIMAL_MODE_EN exposes D on decimal_OUT; undefined (2A03 build) ties decimal_OUT low.
module processor_status_register (
    input  logic       phi2,
    input  logic       reset_N,
    input  logic [7:0] dataBus_IN,
    input  logic       carry_FLAG_IN,
    input  logic       overflow_FLAG_IN,
    input  logic       negative_FLAG_IN,
    input  logic       zero_FLAG_IN,
    input  logic       dataBus_EN,
    input  logic       aluCarry_EN,
    input  logic       aluOverflow_EN,
    input  logic       aluNZ_EN,
    input  logic       dbNZ_EN,
    input  logic       bit_EN,
    input  logic       setCarry_EN,
    input  logic       clearCarry_EN,
    input  logic       setInterrupt_EN,
    input  logic       clearInterrupt_EN,
    input  logic       setDecimal_EN,
    input  logic       clearDecimal_EN,
    input  logic       clearOverflow_EN,
    input  logic       setOverflow_N,
    input  logic       pushBreak_EN,
    output logic [7:0] status_OUT,
    output logic       carry_OUT,
    output logic       zero_OUT,
    output logic       interrupt_OUT,
    output logic       decimal_OUT,
    output logic       overflow_OUT,
    output logic       negative_OUT,
    output logic       irqMask_OUT
);

    logic carry_q, carry_d;
    logic zero_q, zero_d;
    logic interrupt_q, interrupt_d;
    logic decimal_q, decimal_d;
    logic overflow_q, overflow_d;
    logic negative_q, negative_d;
    logic irq_mask_q, irq_mask_d;
    logic so_sync1_q, so_sync1_d;
    logic so_sync2_q, so_sync2_d;
    logic so_prev_q, so_prev_d;
    logic so_fall;
    logic db_zero;

    assign so_fall = so_prev_q & ~so_sync2_q;
    assign db_zero = (dataBus_IN == 8'h00);

    always_comb begin
        so_sync1_d = setOverflow_N;
        so_sync2_d = so_sync1_q;
        so_prev_d  = so_sync2_q;
        irq_mask_d = interrupt_q;

        carry_d = carry_q;
        if (dataBus_EN)
            carry_d = dataBus_IN[0];
        else if (setCarry_EN || clearCarry_EN)
            carry_d = (setCarry_EN && clearCarry_EN) ? carry_q : setCarry_EN;
        else if (aluCarry_EN)
            carry_d = carry_FLAG_IN;

        interrupt_d = interrupt_q;
        if (dataBus_EN)
            interrupt_d = dataBus_IN[2];
        else if (setInterrupt_EN && !clearInterrupt_EN)
            interrupt_d = 1'b1;
        else if (clearInterrupt_EN && !setInterrupt_EN)
            interrupt_d = 1'b0;

        decimal_d = decimal_q;
        if (dataBus_EN)
            decimal_d = dataBus_IN[3];
        else if (setDecimal_EN && !clearDecimal_EN)
            decimal_d = 1'b1;
        else if (clearDecimal_EN && !setDecimal_EN)
            decimal_d = 1'b0;

        // A synchronised SO falling edge beats every other overflow source.
        overflow_d = overflow_q;
        if (so_fall)
            overflow_d = 1'b1;
        else if (dataBus_EN)
            overflow_d = dataBus_IN[6];
        else if (clearOverflow_EN)
            overflow_d = 1'b0;
        else if (bit_EN)
            overflow_d = dataBus_IN[6];
        else if (aluOverflow_EN)
            overflow_d = overflow_FLAG_IN;

        negative_d = negative_q;
        if (dataBus_EN || dbNZ_EN || bit_EN)
            negative_d = dataBus_IN[7];
        else if (aluNZ_EN)
            negative_d = negative_FLAG_IN;

        zero_d = zero_q;
        if (dataBus_EN)
            zero_d = dataBus_IN[1];
        else if (dbNZ_EN)
            zero_d = db_zero;
        else if (aluNZ_EN)
            zero_d = zero_FLAG_IN;
    end

    always_ff @(posedge phi2 or negedge reset_N) begin
        if (!reset_N) begin
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            interrupt_q <= 1'b1;
            decimal_q   <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            irq_mask_q  <= 1'b1;
            so_sync1_q  <= 1'b1;
            so_sync2_q  <= 1'b1;
            so_prev_q   <= 1'b1;
        end else begin
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            interrupt_q <= interrupt_d;
            decimal_q   <= decimal_d;
            overflow_q  <= overflow_d;
            negative_q  <= negative_d;
            irq_mask_q  <= irq_mask_d;
            so_sync1_q  <= so_sync1_d;
            so_sync2_q  <= so_sync2_d;
            so_prev_q   <= so_prev_d;
        end
    end

    // B is not stored; bit 5 always reads 1.
    assign status_OUT    = {negative_q, overflow_q, 1'b1, pushBreak_EN,
                            decimal_q, interrupt_q, zero_q, carry_q};
    assign carry_OUT     = carry_q;
    assign zero_OUT      = zero_q;
    assign interrupt_OUT = interrupt_q;
    assign overflow_OUT  = overflow_q;
    assign negative_OUT  = negative_q;
    assign irqMask_OUT   = irq_mask_q;

`ifdef DECIMAL_MODE_EN
    assign decimal_OUT = decimal_q;
`else
    assign decimal_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_processor_status_register.sv
// Directed bench for processor_status_register: behavioural flag model feeds a scoreboard queue.
module tb_processor_status_register;

    logic       phi2 = 1'b0;
    logic       reset_N;
    logic [7:0] dataBus_IN;
    logic       carry_FLAG_IN, overflow_FLAG_IN, negative_FLAG_IN, zero_FLAG_IN;
    logic       dataBus_EN, aluCarry_EN, aluOverflow_EN, aluNZ_EN, dbNZ_EN, bit_EN;
    logic       setCarry_EN, clearCarry_EN, setInterrupt_EN, clearInterrupt_EN;
    logic       setDecimal_EN, clearDecimal_EN, clearOverflow_EN;
    logic       setOverflow_N, pushBreak_EN;
    logic [7:0] status_OUT;
    logic       carry_OUT, zero_OUT, interrupt_OUT, decimal_OUT, overflow_OUT, negative_OUT;
    logic       irqMask_OUT;

    int vectors = 0;
    int miscompares = 0;

    // Reference flag state and SO pin history
    logic m_c, m_z, m_i, m_d, m_v, m_n, m_irq, m_s1, m_s2, m_prev;

    typedef struct {
        string       tag;
        logic [14:0] vec;
    } exp_t;
    exp_t sb[$];

    processor_status_register dut (
        .phi2(phi2), .reset_N(reset_N), .dataBus_IN(dataBus_IN),
        .carry_FLAG_IN(carry_FLAG_IN), .overflow_FLAG_IN(overflow_FLAG_IN),
        .negative_FLAG_IN(negative_FLAG_IN), .zero_FLAG_IN(zero_FLAG_IN),
        .dataBus_EN(dataBus_EN), .aluCarry_EN(aluCarry_EN), .aluOverflow_EN(aluOverflow_EN),
        .aluNZ_EN(aluNZ_EN), .dbNZ_EN(dbNZ_EN), .bit_EN(bit_EN),
        .setCarry_EN(setCarry_EN), .clearCarry_EN(clearCarry_EN),
        .setInterrupt_EN(setInterrupt_EN), .clearInterrupt_EN(clearInterrupt_EN),
        .setDecimal_EN(setDecimal_EN), .clearDecimal_EN(clearDecimal_EN),
        .clearOverflow_EN(clearOverflow_EN), .setOverflow_N(setOverflow_N),
        .pushBreak_EN(pushBreak_EN), .status_OUT(status_OUT),
        .carry_OUT(carry_OUT), .zero_OUT(zero_OUT), .interrupt_OUT(interrupt_OUT),
        .decimal_OUT(decimal_OUT), .overflow_OUT(overflow_OUT), .negative_OUT(negative_OUT),
        .irqMask_OUT(irqMask_OUT)
    );

    always #5 phi2 = ~phi2;

    function automatic logic [14:0] obs_vec();
        return {status_OUT, carry_OUT, zero_OUT, interrupt_OUT, decimal_OUT,
                overflow_OUT, negative_OUT, irqMask_OUT};
    endfunction

    function automatic logic [14:0] model_vec();
        logic dec;
`ifdef DECIMAL_MODE_EN
        dec = m_d;
`else
        dec = 1'b0;
`endif
        return {m_n, m_v, 1'b1, pushBreak_EN, m_d, m_i, m_z, m_c,
                m_c, m_z, m_i, dec, m_v, m_n, m_irq};
    endfunction

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clr_en();
        dataBus_EN = 0; aluCarry_EN = 0; aluOverflow_EN = 0; aluNZ_EN = 0;
        dbNZ_EN = 0; bit_EN = 0; setCarry_EN = 0; clearCarry_EN = 0;
        setInterrupt_EN = 0; clearInterrupt_EN = 0; setDecimal_EN = 0;
        clearDecimal_EN = 0; clearOverflow_EN = 0;
    endtask

    task automatic model_reset();
        m_c = 0; m_z = 0; m_i = 1; m_d = 0; m_v = 0; m_n = 0;
        m_irq = 1; m_s1 = 1; m_s2 = 1; m_prev = 1;
    endtask

    // Apply current inputs for one phi2 edge; model written as lowest-to-highest override.
    task automatic step(input string tag);
        logic c, z, i, d, v, n;
        exp_t e;
        c = m_c; z = m_z; i = m_i; d = m_d; v = m_v; n = m_n;
        if (aluCarry_EN) c = carry_FLAG_IN;
        if (setCarry_EN && !clearCarry_EN) c = 1;
        if (clearCarry_EN && !setCarry_EN) c = 0;
        if (setCarry_EN && clearCarry_EN) c = m_c;
        if (setInterrupt_EN && !clearInterrupt_EN) i = 1;
        if (clearInterrupt_EN && !setInterrupt_EN) i = 0;
        if (setDecimal_EN && !clearDecimal_EN) d = 1;
        if (clearDecimal_EN && !setDecimal_EN) d = 0;
        if (aluOverflow_EN) v = overflow_FLAG_IN;
        if (bit_EN) v = dataBus_IN[6];
        if (clearOverflow_EN) v = 0;
        if (aluNZ_EN) begin n = negative_FLAG_IN; z = zero_FLAG_IN; end
        if (bit_EN) n = dataBus_IN[7];
        if (dbNZ_EN) begin n = dataBus_IN[7]; z = (dataBus_IN == 8'h00); end
        if (dataBus_EN) begin
            c = dataBus_IN[0]; z = dataBus_IN[1]; i = dataBus_IN[2];
            d = dataBus_IN[3]; v = dataBus_IN[6]; n = dataBus_IN[7];
        end
        if (m_prev && !m_s2) v = 1;
        m_irq = m_i;
        m_prev = m_s2; m_s2 = m_s1; m_s1 = setOverflow_N;
        m_c = c; m_z = z; m_i = i; m_d = d; m_v = v; m_n = n;
        e.tag = tag;
        e.vec = model_vec();
        sb.push_back(e);
        @(posedge phi2);
        @(negedge phi2);
        e = sb.pop_front();
        check(e.tag, obs_vec(), e.vec);
    endtask

    initial begin
        exp_t e;
        clr_en();
        reset_N = 0; dataBus_IN = 8'h00; setOverflow_N = 1; pushBreak_EN = 0;
        carry_FLAG_IN = 0; overflow_FLAG_IN = 0; negative_FLAG_IN = 0; zero_FLAG_IN = 0;
        model_reset();
        repeat (2) @(negedge phi2);
        check("reset_status", {status_OUT, irqMask_OUT}, {8'h24, 1'b1});
        e.tag = "reset_vec"; e.vec = model_vec(); sb.push_back(e);
        e = sb.pop_front();
        check(e.tag, obs_vec(), e.vec);

        // Release mid-cycle with setCarry_EN already high: nothing moves before the edge
        setCarry_EN = 1;
        #2 reset_N = 1;
        #1 check("release_hold", {status_OUT, carry_OUT}, {8'h24, 1'b0});
        step("set_carry");
        check("set_carry_status", {status_OUT, carry_OUT}, {8'h25, 1'b1});

        clr_en(); dataBus_IN = 8'hFF; dataBus_EN = 1; clearCarry_EN = 1;
        step("db_load_ff");
        check("db_ff_status", {status_OUT, carry_OUT}, {8'hEF, 1'b1});
        pushBreak_EN = 1;
        #1 check("db_ff_brk", status_OUT, 8'hFF);
        pushBreak_EN = 0;

        clr_en(); clearInterrupt_EN = 1;
        step("cli_k");
        check("cli_k_irq", {interrupt_OUT, irqMask_OUT}, 2'b01);
        clr_en();
        step("cli_k1");
        check("cli_k1_irq", {interrupt_OUT, irqMask_OUT}, 2'b00);

        clearOverflow_EN = 1; step("clv");
        clr_en(); dataBus_IN = 8'h00; dbNZ_EN = 1; aluNZ_EN = 1;
        negative_FLAG_IN = 1; zero_FLAG_IN = 0;
        step("dbnz_over_alu");
        check("dbnz_zn", {zero_OUT, negative_OUT}, 2'b10);
        clr_en(); dataBus_IN = 8'hC0; bit_EN = 1;
        step("bit_c0");
        check("bit_nv", {negative_OUT, overflow_OUT}, 2'b11);

        clr_en(); dataBus_IN = 8'h00; bit_EN = 1; aluOverflow_EN = 1; aluNZ_EN = 1;
        overflow_FLAG_IN = 1; negative_FLAG_IN = 1; zero_FLAG_IN = 1;
        step("bit_vs_alu");
        clr_en(); setCarry_EN = 1; clearCarry_EN = 1; setDecimal_EN = 1; clearDecimal_EN = 1;
        aluCarry_EN = 1; carry_FLAG_IN = 0;
        step("set_clr_hold");
        clr_en(); aluCarry_EN = 1; carry_FLAG_IN = 0; aluNZ_EN = 1;
        negative_FLAG_IN = 1; zero_FLAG_IN = 0;
        step("alu_load");
        clr_en(); dataBus_IN = 8'h30; dataBus_EN = 1;
        step("db_ignore_b5b4");
        check("db_30_status", status_OUT, 8'h20);

        clr_en(); setDecimal_EN = 1;
        step("sed");
        check1("sed_status_b3", status_OUT[3], 1'b1);
`ifdef DECIMAL_MODE_EN
        check1("sed_decimal_out", decimal_OUT, 1'b1);
`else
        check1("sed_decimal_out", decimal_OUT, 1'b0);
`endif
        clr_en(); setInterrupt_EN = 1; step("sei");

        // SO falling edge: clearOverflow_EN on the detect cycle must lose
        clr_en(); setOverflow_N = 0;
        step("so_e0");
        step("so_e1");
        clearOverflow_EN = 1;
        step("so_set");
        check1("so_overrides_clv", overflow_OUT, 1'b1);
        clr_en(); step("so_idle");
        clearOverflow_EN = 1; step("so_clv");
        check1("so_clv_v", overflow_OUT, 1'b0);
        clr_en();
        for (int k = 0; k < 5; k++) step("so_held_low");
        check1("so_once_v", overflow_OUT, 1'b0);
        setOverflow_N = 1;
        repeat (3) step("so_high");

        // Second SO edge coinciding with a data-bus load of 00
        setOverflow_N = 0;
        step("so2_e0");
        step("so2_e1");
        dataBus_IN = 8'h00; dataBus_EN = 1;
        step("so2_vs_db");
        check1("so_overrides_db", overflow_OUT, 1'b1);
        clr_en(); setOverflow_N = 1;
        repeat (2) step("so2_after");

        // Asynchronous reset mid-cycle
        #2 reset_N = 0;
        model_reset();
        #1 check("reset_async", {status_OUT, carry_OUT, overflow_OUT, irqMask_OUT},
                 {8'h24, 1'b0, 1'b0, 1'b1});
        @(negedge phi2);
        reset_N = 1;
        step("post_reset_idle");

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/processor_status_register.md
PROCESSOR_STATUS_REGISTER -- requirements
Module: processor_status_register

Interface
REQ-001 phi2  input  1  system clock; all state updates on rising edge.
REQ-002 reset_N  input  1  reset, asynchronous, active-low.
REQ-003 dataBus_IN  input  8  data bus value, used for pull (PLP/RTI), load N/Z and BIT.
REQ-004 carry_FLAG_IN, overflow_FLAG_IN, negative_FLAG_IN, zero_FLAG_IN  input  1 each  ALU flag outputs.
REQ-005 dataBus_EN  input  1  load C,Z,I,D,V,N from dataBus_IN bits 0,1,2,3,6,7.
REQ-006 aluCarry_EN / aluOverflow_EN / aluNZ_EN  input  1 each  load C / V / N+Z from ALU flags.
REQ-007 dbNZ_EN  input  1  N <= dataBus_IN[7]; Z <= (dataBus_IN == 0).
REQ-008 bit_EN  input  1  N <= dataBus_IN[7]; V <= dataBus_IN[6].
REQ-009 setCarry_EN, clearCarry_EN, setInterrupt_EN, clearInterrupt_EN, setDecimal_EN, clearDecimal_EN, clearOverflow_EN  input  1 each  explicit flag set/clear.
REQ-010 setOverflow_N  input  1  SO pin, asynchronous to instruction flow, active falling edge.
REQ-011 pushBreak_EN  input  1  B bit value for status_OUT (1 = BRK/PHP, 0 = IRQ/NMI).
REQ-012 status_OUT  output  8  {N,V,1,pushBreak_EN,D,I,Z,C} for stack push.
REQ-013 carry_OUT, zero_OUT, interrupt_OUT, decimal_OUT, overflow_OUT, negative_OUT  output  1 each  stored flags (decimal_OUT per REQ-027).
REQ-014 irqMask_OUT  output  1  interrupt mask seen by interrupt logic.

Function
REQ-015 Flags are registered; any load/set/clear is visible on outputs one phi2 edge after the enable is sampled high.
REQ-016 Enables are sampled every phi2 edge; no enable asserted -> flag holds.
REQ-017 Per-flag priority: dataBus_EN > explicit set/clear > aluX_EN/dbNZ_EN/bit_EN.
REQ-018 Set and clear of the same flag asserted together -> flag unchanged.
REQ-019 aluNZ_EN and dbNZ_EN together -> dbNZ_EN wins for N and Z; bit_EN with aluNZ_EN -> N from bit_EN, Z from ALU.
REQ-020 bit_EN with aluOverflow_EN -> V from bit_EN.
REQ-021 setOverflow_N is registered through two flops then edge-detected; a 1->0 transition seen on the synchronised value sets V on the following edge, overriding every other V source including dataBus_EN and clearOverflow_EN.
REQ-022 setOverflow_N held low sets V only once; V may then be cleared normally.
REQ-023 status_OUT bit 5 is constant 1; bit 4 is combinational pushBreak_EN; B is never stored.
REQ-024 dataBus_IN bits 4 and 5 are ignored on load.
REQ-025 irqMask_OUT = value of I delayed by one phi2 edge (CLI/SEI/PLP take effect after the next instruction boundary).

Reset
REQ-026 reset_N low, asynchronously: C,Z,D,V,N = 0; I = 1; irqMask_OUT = 1; SO synchroniser and edge history = 1; status_OUT = 8'h24 with pushBreak_EN low; reset deassertion mid-sequence ignores enables until the first phi2 edge after release.

Configuration
REQ-027 DECIMAL_MODE_EN defined: decimal_OUT = D. Undefined (2A03 build): decimal_OUT tied 0, D still stored, loaded, set/cleared and pushed in status_OUT bit 3.

Verification
REQ-028 Reset -> status_OUT = 8'h24, irqMask_OUT = 1; release, setCarry_EN 1 cycle -> carry_OUT = 1, status_OUT = 8'h25.
REQ-029 dataBus_IN = 8'hFF, dataBus_EN -> status_OUT = 8'hEF (pushBreak_EN=0), 8'hFF (pushBreak_EN=1); same cycle clearCarry_EN -> carry_OUT still 1.
REQ-030 clearInterrupt_EN at edge k -> interrupt_OUT = 0 after edge k, irqMask_OUT = 0 after edge k+1.
REQ-031 dataBus_IN = 8'h00, dbNZ_EN with aluNZ_EN, negative_FLAG_IN=1 -> zero_OUT = 1, negative_OUT = 0; dataBus_IN = 8'hC0, bit_EN -> N = 1, V = 1.
REQ-032 setOverflow_N 1->0 held 10 cycles with clearOverflow_EN pulsed on synchronised-edge cycle -> V = 1; clearOverflow_EN two cycles later -> V = 0, stays 0.
REQ-033 setDecimal_EN -> status_OUT bit 3 = 1; decimal_OUT = 1 with DECIMAL_MODE_EN, 0 without.
